// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI Wishbone round-robin arbiter.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  localparam int TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/spi_wb_arb_timeout.sv
// Ack watchdog: counts stalled strobe cycles and flags the one that hits the limit.
module spi_wb_arb_timeout #(
  parameter int TIMEOUT = spi_arb_pkg::TIMEOUT_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_stb,
  input  logic i_ack,
  output logic o_err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_stall;
  logic          w_hit;

  assign w_stall = i_stb & ~i_ack;
  assign w_hit   = (r_cnt == CW'(TIMEOUT - 1));
  assign o_err   = w_stall & w_hit;

  // Counter restarts after the error cycle so the next owner starts from zero.
  always_ff @(posedge i_clk) begin
    if (i_rst || !w_stall || o_err) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_wb_arbiter.sv
// Round-robin Wishbone arbiter (M0 = I2C bridge, M1 = boot sequencer) in front of the SPI master.
// Optional ack timeout enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_wb_arbiter
  import spi_arb_pkg::*;
#(
  parameter int AW      = 3,
  parameter int DW      = 8,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic          i2c_wb_clk_i,
  input  logic          i2c_wb_rst_i,

  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic [AW-1:0] m0_adr_i,
  input  logic [DW-1:0] m0_dat_i,
  output logic [DW-1:0] m0_dat_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,

  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [DW-1:0] m1_dat_i,
  output logic [DW-1:0] m1_dat_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,

  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic [AW-1:0] s_adr_o,
  output logic [DW-1:0] s_dat_o,
  input  logic [DW-1:0] s_dat_i,
  input  logic          s_ack_i,

  output logic [1:0]    grant_o
);

  arb_state_t r_state;
  logic [1:0] r_grant;
  logic       r_ptr;
  logic       r_blk0;
  logic       r_blk1;

  logic       w_own0;
  logic       w_own1;
  logic       w_req0;
  logic       w_req1;
  logic       w_tout;

  assign w_own0  = r_grant[0];
  assign w_own1  = r_grant[1];
  assign grant_o = r_grant;

  assign w_req0 = m0_cyc_i & ~r_blk0;
  assign w_req1 = m1_cyc_i & ~r_blk1;

`ifdef SPI_ARB_TIMEOUT_EN
  spi_wb_arb_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .i_clk (i2c_wb_clk_i),
    .i_rst (i2c_wb_rst_i),
    .i_stb (s_stb_o),
    .i_ack (s_ack_i),
    .o_err (w_tout)
  );
  assign m0_err_o = w_tout & w_own0;
  assign m1_err_o = w_tout & w_own1;
`else
  assign w_tout   = 1'b0;
  assign m0_err_o = 1'b0;
  assign m1_err_o = 1'b0;
`endif

  // r_ptr=0 favours M0; a timed-out master stays blocked until it drops cyc for a cycle.
  always_ff @(posedge i2c_wb_clk_i) begin
    if (i2c_wb_rst_i) begin
      r_state <= IDLE;
      r_grant <= GNT_NONE;
      r_ptr   <= 1'b0;
      r_blk0  <= 1'b0;
      r_blk1  <= 1'b0;
    end else begin
      if (!m0_cyc_i) r_blk0 <= 1'b0;
      if (!m1_cyc_i) r_blk1 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req0 && (!w_req1 || !r_ptr)) begin
            r_state <= OWN0;
            r_grant <= GNT_M0;
            r_ptr   <= 1'b1;
          end else if (w_req1) begin
            r_state <= OWN1;
            r_grant <= GNT_M1;
            r_ptr   <= 1'b0;
          end
        end
        OWN0: begin
          if (!m0_cyc_i || w_tout) begin
            r_state <= IDLE;
            r_grant <= GNT_NONE;
            if (w_tout) r_blk0 <= 1'b1;
          end
        end
        OWN1: begin
          if (!m1_cyc_i || w_tout) begin
            r_state <= IDLE;
            r_grant <= GNT_NONE;
            if (w_tout) r_blk1 <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= GNT_NONE;
        end
      endcase
    end
  end

  always_comb begin
    s_cyc_o  = (m0_cyc_i & w_own0) | (m1_cyc_i & w_own1);
    s_stb_o  = (m0_stb_i & w_own0) | (m1_stb_i & w_own1);
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    if (w_own0) begin
      s_we_o  = m0_we_i;
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
    end else if (w_own1) begin
      s_we_o  = m1_we_i;
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
    end
    m0_dat_o = w_own0 ? s_dat_i : '0;
    m1_dat_o = w_own1 ? s_dat_i : '0;
    m0_ack_o = s_ack_i & w_own0;
    m1_ack_o = s_ack_i & w_own1;
  end

endmodule

// File: tb/tb_spi_wb_arbiter.sv
// Directed self-checking bench for spi_wb_arbiter (TIMEOUT=8; covers SPI_ARB_TIMEOUT_EN on or off).
module tb_spi_wb_arbiter;

  localparam int AW = 3;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_cyc, m0_stb, m0_we;
  logic [AW-1:0] m0_adr;
  logic [DW-1:0] m0_dati, m0_dato;
  logic          m0_ack, m0_err;
  logic          m1_cyc, m1_stb, m1_we;
  logic [AW-1:0] m1_adr;
  logic [DW-1:0] m1_dati, m1_dato;
  logic          m1_ack, m1_err;
  logic          s_cyc, s_stb, s_we;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_dato, s_dati;
  logic          s_ack;
  logic [1:0]    grant;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spi_wb_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(8)) dut (
    .i2c_wb_clk_i (clk),
    .i2c_wb_rst_i (rst),
    .m0_cyc_i (m0_cyc), .m0_stb_i (m0_stb), .m0_we_i (m0_we),
    .m0_adr_i (m0_adr), .m0_dat_i (m0_dati), .m0_dat_o (m0_dato),
    .m0_ack_o (m0_ack), .m0_err_o (m0_err),
    .m1_cyc_i (m1_cyc), .m1_stb_i (m1_stb), .m1_we_i (m1_we),
    .m1_adr_i (m1_adr), .m1_dat_i (m1_dati), .m1_dat_o (m1_dato),
    .m1_ack_o (m1_ack), .m1_err_o (m1_err),
    .s_cyc_o (s_cyc), .s_stb_o (s_stb), .s_we_o (s_we),
    .s_adr_o (s_adr), .s_dat_o (s_dato), .s_dat_i (s_dati),
    .s_ack_i (s_ack),
    .grant_o (grant)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; comparisons follow after another unit.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic applyStimulus(input int m, input logic cyc, input logic stb, input logic we,
                               input logic [AW-1:0] adr, input logic [DW-1:0] dat);
    if (m == 0) begin
      m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_adr = adr; m0_dati = dat;
    end else begin
      m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_adr = adr; m1_dati = dat;
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    s_ack = 1'b0;
    s_dati = '0;
    step();
    step();
    rst = 1'b0;
    settle();
  endtask

  initial begin
    doReset();
    $display("[TB] reset state");
    checkOutput("rst_grant", 32'(grant), 32'h0);
    checkOutput("rst_scyc", 32'({s_cyc, s_stb, s_we}), 32'h0);
    checkOutput("rst_sadr_dat", 32'({s_adr, s_dato}), 32'h0);
    checkOutput("rst_mdat", 32'({m0_dato, m1_dato}), 32'h0);
    checkOutput("rst_ack_err", 32'({m0_ack, m1_ack, m0_err, m1_err}), 32'h0);

    $display("[TB] M0 single write");
    applyStimulus(0, 1, 1, 1, 3'd2, 8'hA5);
    settle();
    checkOutput("m0_pre_grant", 32'(grant), 32'h0);
    checkOutput("m0_pre_scyc", 32'(s_cyc), 32'h0);
    step();
    checkOutput("m0_grant", 32'(grant), 32'h1);
    checkOutput("m0_scyc_stb_we", 32'({s_cyc, s_stb, s_we}), 32'h7);
    checkOutput("m0_sadr", 32'(s_adr), 32'h2);
    checkOutput("m0_sdat", 32'(s_dato), 32'hA5);
    checkOutput("m0_noack", 32'(m0_ack), 32'h0);
    s_ack = 1'b1;
    settle();
    checkOutput("m0_ack", 32'(m0_ack), 32'h1);
    checkOutput("m1_noack", 32'(m1_ack), 32'h0);
    step();
    s_ack = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    step();
    checkOutput("m0_release", 32'(grant), 32'h0);

    $display("[TB] strict alternation");
    doReset();
    applyStimulus(0, 1, 1, 0, 3'd1, 8'h11);
    applyStimulus(1, 1, 1, 0, 3'd4, 8'h22);
    step();
    checkOutput("alt1_grant", 32'(grant), 32'h1);
    checkOutput("alt1_sadr", 32'(s_adr), 32'h1);
    s_ack = 1'b1;
    settle();
    checkOutput("alt1_m1_noack", 32'(m1_ack), 32'h0);
    s_ack = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    step();
    checkOutput("alt1_idle", 32'(grant), 32'h0);
    applyStimulus(0, 1, 1, 0, 3'd1, 8'h11);
    applyStimulus(1, 1, 1, 0, 3'd4, 8'h22);
    step();
    checkOutput("alt2_grant", 32'(grant), 32'h2);
    checkOutput("alt2_sadr", 32'(s_adr), 32'h4);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    step();
    checkOutput("alt2_idle", 32'(grant), 32'h0);
    applyStimulus(0, 1, 1, 0, 3'd1, 8'h11);
    applyStimulus(1, 1, 1, 0, 3'd4, 8'h22);
    step();
    checkOutput("alt3_grant", 32'(grant), 32'h1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    step();

    $display("[TB] M1 locked sequence with M0 waiting");
    applyStimulus(0, 1, 1, 1, 3'd7, 8'hFF);
    applyStimulus(1, 1, 1, 1, 3'd3, 8'h01);
    step();
    checkOutput("lk_grant", 32'(grant), 32'h2);
    checkOutput("lk_ss", 32'({s_we, s_adr, s_dato}), {21'd0, 1'b1, 3'd3, 8'h01});
    s_ack = 1'b1;
    settle();
    checkOutput("lk_ss_ack", 32'({m1_ack, m0_ack}), 32'h2);
    step();
    s_ack = 1'b0;
    applyStimulus(1, 1, 1, 1, 3'd1, 8'h3C);
    settle();
    checkOutput("lk_tx", 32'({s_we, s_adr, s_dato}), {21'd0, 1'b1, 3'd1, 8'h3C});
    step();
    s_ack = 1'b1;
    settle();
    checkOutput("lk_tx_ack", 32'({m1_ack, m0_ack}), 32'h2);
    step();
    s_ack = 1'b0;
    applyStimulus(1, 1, 1, 0, 3'd0, 8'h00);
    s_dati = 8'h5A;
    settle();
    checkOutput("lk_rx_we", 32'({s_we, s_adr}), 32'h0);
    s_ack = 1'b1;
    settle();
    checkOutput("lk_rx_dat", 32'(m1_dato), 32'h5A);
    checkOutput("lk_m0_dat", 32'(m0_dato), 32'h0);
    checkOutput("lk_grant_hold", 32'(grant), 32'h2);
    step();
    s_ack = 1'b0;
    s_dati = '0;
    applyStimulus(1, 0, 0, 0, 0, 0);
    step();
    checkOutput("lk_gap", 32'(grant), 32'h0);
    checkOutput("lk_gap_scyc", 32'(s_cyc), 32'h0);
    step();
    checkOutput("lk_m0_grant", 32'(grant), 32'h1);
    checkOutput("lk_m0_sadr", 32'({s_adr, s_dato}), {21'd0, 3'd7, 8'hFF});
    applyStimulus(0, 0, 0, 0, 0, 0);
    step();

    $display("[TB] owner drops cyc with ack");
    applyStimulus(0, 1, 1, 1, 3'd5, 8'h77);
    step();
    checkOutput("dr_grant", 32'(grant), 32'h1);
    applyStimulus(0, 0, 1, 1, 3'd5, 8'h77);
    applyStimulus(1, 1, 1, 0, 3'd6, 8'h00);
    s_ack = 1'b1;
    settle();
    checkOutput("dr_ack", 32'({m0_ack, m1_ack}), 32'h2);
    step();
    checkOutput("dr_idle", 32'(grant), 32'h0);
    checkOutput("dr_noack_idle", 32'({m0_ack, m1_ack}), 32'h0);
    s_ack = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    step();
    checkOutput("dr_m1_grant", 32'(grant), 32'h2);
    applyStimulus(1, 0, 0, 0, 0, 0);
    step();

    $display("[TB] reset mid-transfer");
    applyStimulus(0, 1, 1, 1, 3'd2, 8'h12);
    step();
    checkOutput("mr_grant", 32'(grant), 32'h1);
    rst = 1'b1;
    step();
    checkOutput("mr_grant_drop", 32'(grant), 32'h0);
    checkOutput("mr_scyc", 32'(s_cyc), 32'h0);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    s_ack = 1'b1;
    settle();
    checkOutput("mr_ack_idle", 32'({m0_ack, m1_ack}), 32'h0);
    s_ack = 1'b0;
    applyStimulus(0, 1, 1, 0, 3'd1, 8'h00);
    applyStimulus(1, 1, 1, 0, 3'd2, 8'h00);
    step();
    checkOutput("mr_after", 32'(grant), 32'h1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    step();

    $display("[TB] slave never acks M1");
    applyStimulus(0, 1, 1, 0, 3'd1, 8'h00);
    applyStimulus(1, 1, 1, 0, 3'd2, 8'h00);
    step();
    checkOutput("to_grant", 32'(grant), 32'h2);
`ifdef SPI_ARB_TIMEOUT_EN
    for (int i = 1; i <= 8; i++) begin
      checkOutput($sformatf("to_err_c%0d", i), 32'(m1_err), 32'((i == 8) ? 1 : 0));
      checkOutput($sformatf("to_m0err_c%0d", i), 32'({m0_err, m1_ack}), 32'h0);
      if (i < 8) step();
    end
    step();
    checkOutput("to_idle", 32'(grant), 32'h0);
    checkOutput("to_scyc", 32'(s_cyc), 32'h0);
    checkOutput("to_err_clear", 32'(m1_err), 32'h0);
    step();
    checkOutput("to_m0_grant", 32'(grant), 32'h1);
`else
    for (int i = 1; i <= 20; i++) begin
      checkOutput($sformatf("hold_err_c%0d", i), 32'({m0_err, m1_err}), 32'h0);
      checkOutput($sformatf("hold_grant_c%0d", i), 32'(grant), 32'h2);
      step();
    end
`endif
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
